sad_window_accum: RTL and testbench

//  Streaming, parametrised sum-of-pixel-differences engine for template/motion matching.

---
 rtl/sad_pkg.sv | 27 ++
 rtl/sad_window_accum_if.sv | 34 +++
 rtl/sad_row_adder.sv | 30 +++
 rtl/sad_window_accum.sv | 153 +++++++++++++++
 tb/tb_sad_window_accum.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared constants and arithmetic helpers for the SAD window accumulator.
package sad_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_DEF   = 11;
    localparam int SUM_W_DEF = 16;

    // Accumulator width that can never overflow for a full window.
    function automatic int sum_w_min(input int pix_w, input int win);
        return pix_w + $clog2(win * win);
    endfunction

    // Add a and b, clamping at 2^w-1. Bit 64 of the result flags a clamp.
    function automatic logic [64:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [64:0] s;
        logic [63:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (s > {1'b0, lim}) begin
            return {1'b1, lim};
        end
        return {1'b0, s[63:0]};
    endfunction

endpackage

// File: rtl/sad_window_accum_if.sv
// Row input stream, result output stream and min-tracker control.
interface sad_window_accum_if
    import sad_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int WIN   = WIN_DEF,
    parameter int SUM_W = SUM_W_DEF
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIN*PIX_W-1:0]   in_row;
    logic                   in_first;
    logic [SUM_W-1:0]       thresh;
    logic                   out_valid;
    logic                   out_ready;
    logic [SUM_W-1:0]       out_sum;
    logic                   out_below;
    logic                   out_sat;
    logic                   min_clear;
    logic [SUM_W-1:0]       out_min;
    logic                   sync_err;

    // Producer/consumer side
    modport master (
        output in_valid, in_row, in_first, thresh, out_ready, min_clear,
        input  in_ready, out_valid, out_sum, out_below, out_sat, out_min, sync_err
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_row, in_first, thresh, out_ready, min_clear,
        output in_ready, out_valid, out_sum, out_below, out_sat, out_min, sync_err
    );
endinterface

// File: rtl/sad_row_adder.sv
// Balanced combinational adder tree summing the WIN pixels of one row.
module sad_row_adder #(
    parameter int PIX_W = 8,
    parameter int WIN   = 11,
    localparam int OUT_W = PIX_W + $clog2(WIN)
) (
    input  logic [WIN*PIX_W-1:0] row,
    output logic [OUT_W-1:0]     sum
);
    // Leaves padded to a power of two; heap layout, node[1] is the root.
    localparam int NP = 1 << $clog2(WIN);

    logic [OUT_W-1:0] node [1:2*NP-1];

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_leaf
            if (gi < WIN) begin : g_pix
                assign node[NP+gi] = OUT_W'(row[gi*PIX_W +: PIX_W]);
            end else begin : g_pad
                assign node[NP+gi] = '0;
            end
        end
        for (gi = 1; gi < NP; gi++) begin : g_tree
            assign node[gi] = node[2*gi] + node[2*gi+1];
        end
    endgenerate

    assign sum = node[1];
endmodule

// File: rtl/sad_window_accum.sv
// Streaming window sum-of-differences: row adder, row counter, saturating
// accumulator, held output register and running-minimum tracker.
module sad_window_accum
    import sad_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int WIN   = WIN_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    sad_window_accum_if.slave bus
);
    localparam int RS_W  = PIX_W + $clog2(WIN);
    localparam int CNT_W = $clog2(WIN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

    logic [RS_W-1:0]  row_sum;
    logic             accept;
    logic             xfer;
    logic             first_eff;
    logic             last_row;
    logic [CNT_W-1:0] row_idx;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d;
    logic [RS_W-1:0]  s1_sum_q, s1_sum_d;
    logic             sync_err_q, sync_err_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [SUM_W-1:0] acc_base;
    logic [64:0]      add_res;
    logic             unused_add_hi;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic             out_below_q, out_below_d;
    logic             out_sat_q, out_sat_d;
    logic [SUM_W-1:0] out_min_q, out_min_d;

    sad_row_adder #(.PIX_W(PIX_W), .WIN(WIN)) u_row_adder (
        .row (bus.in_row),
        .sum (row_sum)
    );

    // A held result blocks new rows; stage 2 can always drain.
    assign bus.in_ready = !(out_valid_q && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_below = out_below_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_min   = out_min_q;
    assign bus.sync_err  = sync_err_q;

    // Row position tracking and stage-1 capture of the row sum and flags.
    always_comb begin
        first_eff  = bus.in_first || (row_cnt_q == '0);
        row_idx    = first_eff ? '0 : row_cnt_q;
        last_row   = (row_idx == LAST_IDX);
        row_cnt_d  = row_cnt_q;
        sync_err_d = 1'b0;
        s1_valid_d = accept;
        s1_sum_d   = s1_sum_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (accept) begin
            // A mid-window in_first restarts the window on this row.
            row_cnt_d  = last_row ? '0 : row_idx + CNT_W'(1);
            sync_err_d = bus.in_first && (row_cnt_q != '0);
            s1_sum_d   = row_sum;
            s1_first_d = first_eff;
            s1_last_d  = last_row;
        end
    end

    // Stage 2 accumulation, result capture and min tracking.
    always_comb begin
        acc_base    = s1_first_q ? '0 : acc_q;
        add_res     = sat_add(64'(acc_base), 64'(s1_sum_q), SUM_W);
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_below_d = out_below_q;
        out_sat_d   = out_sat_q;
        out_min_d   = out_min_q;
        if (s1_valid_q) begin
            acc_d = add_res[SUM_W-1:0];
            sat_d = add_res[64] | (s1_first_q ? 1'b0 : sat_q);
        end
        if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (s1_valid_q && s1_last_q) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_d;
            out_sat_d   = sat_d;
            out_below_d = acc_d < bus.thresh;
        end
        if (xfer) begin
            if (bus.min_clear || (out_sum_q < out_min_q)) begin
                out_min_d = out_sum_q;
            end
        end else if (bus.min_clear) begin
            out_min_d = '1;
        end
    end

    assign unused_add_hi = ^add_res[63:SUM_W];

    // Stage-1 and row-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            sync_err_q <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_sum_q   <= s1_sum_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Accumulator, output and minimum registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_below_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_min_q   <= '1;
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_below_q <= out_below_d;
            out_sat_q   <= out_sat_d;
            out_min_q   <= out_min_d;
        end
    end
endmodule

// File: tb/tb_sad_window_accum.sv
// Directed bench: a 16-bit and a 14-bit accumulator fed the same row stream.
module tb_sad_window_accum;
    import sad_pkg::*;

    localparam int PIX_W = 8;
    localparam int WIN   = 11;
    localparam int RW    = PIX_W * WIN;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_first  = 1'b0;
    logic          out_ready = 1'b1;
    logic          min_clear = 1'b0;
    logic [RW-1:0] in_row    = '0;
    logic [15:0]   thresh    = 16'd40000;

    int total = 0;
    int bad   = 0;
    int sync_pulses = 0;
    int sync_base;

    int win_sums  [3] = '{500, 300, 900};
    int win_mins  [3] = '{500, 300, 300};
    int win_below [3] = '{0, 1, 0};

    sad_window_accum_if #(.PIX_W(PIX_W), .WIN(WIN), .SUM_W(16)) if16 ();
    sad_window_accum_if #(.PIX_W(PIX_W), .WIN(WIN), .SUM_W(14)) if14 ();

    assign if16.in_valid  = in_valid;
    assign if16.in_first  = in_first;
    assign if16.in_row    = in_row;
    assign if16.thresh    = thresh;
    assign if16.out_ready = out_ready;
    assign if16.min_clear = min_clear;
    assign if14.in_valid  = in_valid;
    assign if14.in_first  = in_first;
    assign if14.in_row    = in_row;
    assign if14.thresh    = thresh[13:0];
    assign if14.out_ready = out_ready;
    assign if14.min_clear = min_clear;

    sad_window_accum #(.PIX_W(PIX_W), .WIN(WIN), .SUM_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if16.slave)
    );

    sad_window_accum #(.PIX_W(PIX_W), .WIN(WIN), .SUM_W(14)) dut14 (
        .clk   (clk),
        .reset (reset),
        .bus   (if14.slave)
    );

    always #5 clk = ~clk;

    // Count cycles with sync_err high on the 16-bit instance.
    always @(posedge clk) begin
        if (if16.sync_err === 1'b1) sync_pulses <= sync_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] urow(input int p);
        logic [RW-1:0] r;
        for (int k = 0; k < WIN; k++) r[k*PIX_W +: PIX_W] = p[PIX_W-1:0];
        return r;
    endfunction

    // Present one row and return just after the edge that accepts it.
    task automatic push_row(input logic [RW-1:0] row, input logic first);
        int n = 0;
        in_row   = row;
        in_first = first;
        in_valid = 1'b1;
        while (if16.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("ready_timeout", if16.in_ready, 1);
        tick();
    endtask

    // Window of uniform 'fill' pixels, or (sum_total > 0) a window whose
    // pixel 0 column carries sum_total in chunks of up to 255.
    task automatic send_window(input int sum_total, input int fill, input logic first);
        int rem = sum_total;
        int p0;
        logic [RW-1:0] row;
        for (int r = 0; r < WIN; r++) begin
            row = urow(fill);
            if (sum_total > 0) begin
                p0  = (rem > 255) ? 255 : rem;
                rem = rem - p0;
                row[PIX_W-1:0] = p0[PIX_W-1:0];
            end
            push_row(row, first && (r == 0));
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (if16.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_wait", if16.out_valid, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_out_valid", if16.out_valid, 0);
        check("rst_out_sum", if16.out_sum, 0);
        check("rst_out_min", if16.out_min, 16'hFFFF);
        check("rst_in_ready", if16.in_ready, 1);
        check("rst_sync_err", if16.sync_err, 0);
        reset = 1'b0;
        tick();

        // All-255 window, latency and threshold
        send_window(0, 255, 1'b1);
        check("lat_edge1_valid", if16.out_valid, 0);
        tick();
        check("lat_edge2_valid", if16.out_valid, 1);
        check("w255_sum", if16.out_sum, 30855);
        check("w255_below", if16.out_below, 1);
        check("w255_sat", if16.out_sat, 0);
        check("w255_sum14", if14.out_sum, 16383);
        check("w255_sat14", if14.out_sat, 1);
        tick();
        check("w255_xfer_valid", if16.out_valid, 0);
        check("w255_min", if16.out_min, 30855);

        // Saturation cleared by the next window on the narrow instance
        send_window(0, 1, 1'b1);
        wait_valid();
        check("w1_sum14", if14.out_sum, 121);
        check("w1_sat14", if14.out_sat, 0);
        check("w1_sum", if16.out_sum, 121);
        tick();

        // Output stall with input held valid
        out_ready = 1'b0;
        send_window(0, 3, 1'b1);
        wait_valid();
        check("w3_sum", if16.out_sum, 363);
        in_row   = urow(4);
        in_first = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_in_ready", if16.in_ready, 0);
            check("stall_out_valid", if16.out_valid, 1);
            check("stall_out_sum", if16.out_sum, 363);
            tick();
        end
        out_ready = 1'b1;
        send_window(0, 4, 1'b1);
        wait_valid();
        check("w4_after_stall_sum", if16.out_sum, 484);
        tick();

        // in_first in the middle of a window
        sync_base = sync_pulses;
        for (int i = 0; i < 5; i++) push_row(urow(9), i == 0);
        push_row(urow(5), 1'b1);
        check("sync_err_pulse", if16.sync_err, 1);
        for (int i = 0; i < 10; i++) push_row(urow(5), 1'b0);
        in_valid = 1'b0;
        check("sync_err_low", if16.sync_err, 0);
        wait_valid();
        check("resync_sum", if16.out_sum, 605);
        check("sync_err_count", sync_pulses - sync_base, 1);
        tick();

        // Running minimum
        thresh    = 16'd400;
        min_clear = 1'b1;
        tick();
        min_clear = 1'b0;
        check("min_clear_idle", if16.out_min, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            send_window(win_sums[i], 0, 1'b1);
            wait_valid();
            check("minw_sum", if16.out_sum, win_sums[i]);
            check("minw_below", if16.out_below, win_below[i]);
            tick();
            check("minw_min", if16.out_min, win_mins[i]);
        end
        min_clear = 1'b1;
        tick();
        min_clear = 1'b0;
        check("min_clear_alone", if16.out_min, 16'hFFFF);
        send_window(700, 0, 1'b1);
        wait_valid();
        tick();
        check("min_after_700", if16.out_min, 700);
        send_window(800, 0, 1'b1);
        wait_valid();
        min_clear = 1'b1;
        tick();
        min_clear = 1'b0;
        check("min_clear_with_xfer", if16.out_min, 800);

        // Reset mid-window, then a window without in_first
        sync_base = sync_pulses;
        for (int i = 0; i < 6; i++) push_row(urow(7), i == 0);
        in_valid = 1'b0;
        in_first = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_out_valid", if16.out_valid, 0);
        check("mid_rst_out_sum", if16.out_sum, 0);
        check("mid_rst_out_sat14", if14.out_sat, 0);
        check("mid_rst_out_below", if16.out_below, 0);
        check("mid_rst_out_min", if16.out_min, 16'hFFFF);
        reset = 1'b0;
        tick();
        send_window(0, 2, 1'b0);
        wait_valid();
        check("post_rst_sum", if16.out_sum, 242);
        check("post_rst_sync", sync_pulses - sync_base, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
